// File: rtl/spi_xfer_ctrl_if.sv
// Signal bundle between the APB register block, the SPI transfer sequencer and the shift register.
// Optional SPI_MODF_EN adds the ss_fault_n input and the sticky modf flag.
interface spi_xfer_ctrl_if;
    logic       spe;
    logic       cpol;
    logic       cpha;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       start;
    logic       spif_clr;
    logic       send_data;
    logic       recieve_data;
    logic       ss;
    logic       sclk;
    logic       mosi_send_sclk;
    logic       miso_recieve_sclk;
    logic       mosi_send_sclk0;
    logic       miso_recieve_sclk0;
    logic       tip;
    logic       spif;
`ifdef SPI_MODF_EN
    logic       ss_fault_n;
    logic       modf;
`endif

    modport master (
        input  spe, cpol, cpha, sppr, spr, start, spif_clr,
        output send_data, recieve_data, ss, sclk,
               mosi_send_sclk, miso_recieve_sclk, mosi_send_sclk0, miso_recieve_sclk0,
               tip, spif
`ifdef SPI_MODF_EN
        , input ss_fault_n
        , output modf
`endif
    );

    modport slave (
        output spe, cpol, cpha, sppr, spr, start, spif_clr,
        input  send_data, recieve_data, ss, sclk,
               mosi_send_sclk, miso_recieve_sclk, mosi_send_sclk0, miso_recieve_sclk0,
               tip, spif
`ifdef SPI_MODF_EN
        , output ss_fault_n
        , input modf
`endif
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: SCLK generation, ss/load/capture pulses and per-edge shift strobes.
// Optional mode-fault detection is enabled with SPI_MODF_EN.
module spi_xfer_ctrl (
    input  logic             pclk,
    input  logic             preset,
    spi_xfer_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ACTIVE, TAIL} state_e;

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [3:0]  eidx_q, eidx_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic [2:0]  sppr_q, sppr_d;
    logic [2:0]  spr_q, spr_d;
    logic        sclk_q, sclk_d;
    logic        spif_q, spif_d;

    logic [10:0] half;
    logic [9:0]  hmax;
    logic        fault;
    logic        ok;
    logic        busy;
    logic        tick;
    logic        send_stb;
    logic        samp_stb;

`ifdef SPI_MODF_EN
    logic modf_q, modf_d;

    assign fault = !bus.ss_fault_n;

    always_comb begin
        modf_d = modf_q;
        if (bus.spif_clr) modf_d = 1'b0;
        if (state_q != IDLE && fault) modf_d = 1'b1;
    end

    always_ff @(posedge pclk) begin
        if (preset) modf_q <= 1'b0;
        else        modf_q <= modf_d;
    end

    assign bus.modf = modf_q;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        half     = (11'(sppr_q) + 11'd1) << spr_q;
        hmax     = 10'(half - 11'd1);
        busy     = (state_q != IDLE);
        ok       = bus.spe && !fault && !preset;
        tick     = (state_q == ACTIVE) && (cnt_q == hmax);

        state_d  = state_q;
        cnt_d    = cnt_q;
        eidx_d   = eidx_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        sppr_d   = sppr_q;
        spr_d    = spr_q;
        sclk_d   = sclk_q;
        spif_d   = spif_q;
        send_stb = 1'b0;
        samp_stb = 1'b0;

        bus.send_data          = 1'b0;
        bus.recieve_data       = 1'b0;
        bus.mosi_send_sclk     = 1'b0;
        bus.miso_recieve_sclk  = 1'b0;
        bus.mosi_send_sclk0    = 1'b0;
        bus.miso_recieve_sclk0 = 1'b0;
        bus.ss                 = !busy;
        bus.tip                = busy;
        bus.sclk               = sclk_q;
        bus.spif               = spif_q;

        if (bus.spif_clr) spif_d = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                if (bus.start && bus.spe && !fault) begin
                    state_d = LOAD;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    sppr_d  = bus.sppr;
                    spr_d   = bus.spr;
                end
            end
            LOAD: begin
                bus.send_data = ok;
                state_d       = ACTIVE;
                cnt_d         = '0;
                eidx_d        = '0;
            end
            ACTIVE: begin
                if (tick) begin
                    cnt_d  = '0;
                    eidx_d = eidx_q + 4'd1;
                    if (cpha_q) begin
                        if (eidx_q[0]) samp_stb = 1'b1;
                        else           send_stb = 1'b1;
                    end else begin
                        if (eidx_q[0]) send_stb = (eidx_q != 4'd15);
                        else           samp_stb = 1'b1;
                    end
                    if (eidx_q == 4'd15) state_d = TAIL;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
                // cpha=0 shifts the first bit out as soon as the clock starts
                if (!cpha_q && eidx_q == 4'd0 && cnt_q == '0) send_stb = 1'b1;
            end
            TAIL: begin
                if (cnt_q == hmax) begin
                    bus.recieve_data = ok;
                    if (ok) spif_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // sclk is registered one cycle ahead so its edge lands in the tick cycle itself
        if ((state_q == LOAD || state_q == ACTIVE) && state_d == ACTIVE && cnt_d == hmax)
            sclk_d = ~sclk_q;

        if (busy && !ok) begin
            state_d  = IDLE;
            sclk_d   = bus.cpol;
            send_stb = 1'b0;
            samp_stb = 1'b0;
        end

        if (cpol_q == cpha_q) begin
            bus.mosi_send_sclk     = send_stb;
            bus.miso_recieve_sclk  = samp_stb;
        end else begin
            bus.mosi_send_sclk0    = send_stb;
            bus.miso_recieve_sclk0 = samp_stb;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eidx_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sppr_q  <= '0;
            spr_q   <= '0;
            sclk_q  <= 1'b0;
            spif_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eidx_q  <= eidx_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sppr_q  <= sppr_d;
            spr_q   <= spr_d;
            sclk_q  <= sclk_d;
            spif_q  <= spif_d;
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed self-checking bench for spi_xfer_ctrl; covers the mode-fault path when SPI_MODF_EN is defined.
module tb_spi_xfer_ctrl;
    logic pclk = 1'b0;
    logic preset;

    spi_xfer_ctrl_if ifc ();

    spi_xfer_ctrl dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (ifc)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc = cyc + 1;

    int n_chk = 0;
    int n_bad = 0;
    int t, L;

    int n_ld, n_s, n_r, n_s0, n_r0, n_rd, n_tog;
    int f_ld, f_r, f_s0, f_rd, t_tog1, t_tog2, t_togl;
    logic [15:0] m_s, m_r;
    logic prev_sclk;

    // Event log sampled late in each cycle, after any input change made in that cycle.
    always @(negedge pclk) begin
        #4;
        if (ifc.sclk !== prev_sclk) begin
            n_tog++;
            if (n_tog == 1) t_tog1 = cyc;
            if (n_tog == 2) t_tog2 = cyc;
            t_togl = cyc;
        end
        prev_sclk = ifc.sclk;
        if (ifc.send_data) begin n_ld++; if (f_ld < 0) f_ld = cyc; end
        if (ifc.recieve_data) begin n_rd++; if (f_rd < 0) f_rd = cyc; end
        if (ifc.mosi_send_sclk) n_s++;
        if (ifc.miso_recieve_sclk) begin n_r++; if (f_r < 0) f_r = cyc; end
        if (ifc.mosi_send_sclk0) begin n_s0++; if (f_s0 < 0) f_s0 = cyc; end
        if (ifc.miso_recieve_sclk0) n_r0++;
        if (n_tog >= 1 && n_tog <= 16) begin
            if (ifc.mosi_send_sclk || ifc.mosi_send_sclk0) m_s[n_tog-1] = 1'b1;
            if (ifc.miso_recieve_sclk || ifc.miso_recieve_sclk0) m_r[n_tog-1] = 1'b1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic mon_clr();
        n_ld = 0; n_s = 0; n_r = 0; n_s0 = 0; n_r0 = 0; n_rd = 0; n_tog = 0;
        f_ld = -1; f_r = -1; f_s0 = -1; f_rd = -1;
        t_tog1 = -1; t_tog2 = -1; t_togl = -1;
        m_s = '0; m_r = '0;
        prev_sclk = ifc.sclk;
    endtask

    task automatic wait_cyc(input int c);
        @(negedge pclk);
        while (cyc < c) @(negedge pclk);
        #3;
    endtask

    // Pulses start for one cycle; t is the sampling cycle and L the LOAD cycle.
    task automatic xfer_start();
        mon_clr();
        t = cyc;
        ifc.start = 1'b1;
        wait_cyc(t + 1);
        ifc.start = 1'b0;
        L = cyc;
    endtask

    task automatic clr_spif(input string tag);
        ifc.spif_clr = 1'b1;
        wait_cyc(cyc + 1);
        ifc.spif_clr = 1'b0;
        chk(tag, ifc.spif, 0);
    endtask

    initial begin
        preset = 1'b1;
        ifc.spe = 1'b0; ifc.cpol = 1'b0; ifc.cpha = 1'b0;
        ifc.sppr = 3'd0; ifc.spr = 3'd0;
        ifc.start = 1'b0; ifc.spif_clr = 1'b0;
`ifdef SPI_MODF_EN
        ifc.ss_fault_n = 1'b1;
`endif
        mon_clr();
        wait_cyc(3);
        chk("rst_ss", ifc.ss, 1);
        chk("rst_sclk", ifc.sclk, 0);
        chk("rst_tip", ifc.tip, 0);
        chk("rst_spif", ifc.spif, 0);
        chk("rst_pulses", int'({ifc.send_data, ifc.recieve_data, ifc.mosi_send_sclk,
            ifc.miso_recieve_sclk, ifc.mosi_send_sclk0, ifc.miso_recieve_sclk0}), 0);
`ifdef SPI_MODF_EN
        chk("rst_modf", ifc.modf, 0);
`endif
        preset = 1'b0;
        ifc.spe = 1'b1;
        wait_cyc(cyc + 2);

        // Mode 0, H=1
        xfer_start();
        wait_cyc(t + 19);
        chk("m0_ld_cyc", f_ld, t + 1);
        chk("m0_ld_cnt", n_ld, 1);
        chk("m0_tog_cnt", n_tog, 16);
        chk("m0_tog_first", t_tog1, t + 2);
        chk("m0_tog_last", t_togl, t + 17);
        chk("m0_samp_cnt", n_r, 8);
        chk("m0_samp_first", f_r, t + 2);
        chk("m0_samp_mask", int'(m_r), 'h5555);
        chk("m0_send_cnt", n_s, 8);
        chk("m0_pair0_cnt", n_s0 + n_r0, 0);
        chk("m0_rd_cyc", f_rd, t + 18);
        chk("m0_rd_cnt", n_rd, 1);
        chk("m0_spif", ifc.spif, 1);
        chk("m0_ss_end", ifc.ss, 1);
        chk("m0_tip_end", ifc.tip, 0);
        chk("m0_sclk_end", ifc.sclk, 0);
        clr_spif("m0_spif_clr");

        // Mode 1, H=6
        ifc.cpha = 1'b1; ifc.sppr = 3'd2; ifc.spr = 3'd1;
        wait_cyc(cyc + 1);
        xfer_start();
        wait_cyc(L + 104);
        chk("m1_tog1", t_tog1, L + 6);
        chk("m1_tog2", t_tog2, L + 12);
        chk("m1_tog_cnt", n_tog, 16);
        chk("m1_rd_cyc", f_rd, L + 102);
        chk("m1_send0_cnt", n_s0, 8);
        chk("m1_samp0_cnt", n_r0, 8);
        chk("m1_pair_cnt", n_s + n_r, 0);
        chk("m1_send0_first", f_s0, L + 6);
        chk("m1_send_mask", int'(m_s), 'h5555);
        chk("m1_samp_mask", int'(m_r), 'haaaa);
        chk("m1_spif", ifc.spif, 1);
        clr_spif("m1_spif_clr");

        // Mode 3, H=1
        ifc.cpol = 1'b1; ifc.cpha = 1'b1; ifc.sppr = 3'd0; ifc.spr = 3'd0;
        wait_cyc(cyc + 2);
        chk("m3_sclk_idle", ifc.sclk, 1);
        xfer_start();
        wait_cyc(L + 18);
        chk("m3_sclk_end", ifc.sclk, 1);
        chk("m3_tog_cnt", n_tog, 16);
        chk("m3_send_cnt", n_s, 8);
        chk("m3_samp_cnt", n_r, 8);
        chk("m3_pair0_cnt", n_s0 + n_r0, 0);
        chk("m3_send_mask", int'(m_s), 'h5555);
        chk("m3_samp_mask", int'(m_r), 'haaaa);
        clr_spif("m3_spif_clr");

        // spe abort at L+5, then start blocked while spe is low
        ifc.cpol = 1'b0; ifc.cpha = 1'b0;
        wait_cyc(cyc + 2);
        xfer_start();
        wait_cyc(L + 5);
        ifc.spe = 1'b0;
        wait_cyc(L + 6);
        chk("ab_ss", ifc.ss, 1);
        chk("ab_tip", ifc.tip, 0);
        chk("ab_sclk", ifc.sclk, 0);
        wait_cyc(L + 25);
        chk("ab_rd_cnt", n_rd, 0);
        chk("ab_spif", ifc.spif, 0);
        mon_clr();
        ifc.start = 1'b1;
        wait_cyc(cyc + 1);
        ifc.start = 1'b0;
        wait_cyc(cyc + 4);
        chk("nospe_ld_cnt", n_ld, 0);
        chk("nospe_ss", ifc.ss, 1);
        ifc.spe = 1'b1;
        wait_cyc(cyc + 1);

        // start mid-transfer ignored; spif set beats spif_clr
        xfer_start();
        wait_cyc(L + 5);
        ifc.start = 1'b1;
        wait_cyc(L + 6);
        ifc.start = 1'b0;
        wait_cyc(L + 17);
        ifc.spif_clr = 1'b1;
        wait_cyc(L + 18);
        ifc.spif_clr = 1'b0;
        chk("coll_spif", ifc.spif, 1);
        chk("coll_ld_cnt", n_ld, 1);
        chk("coll_rd_cyc", f_rd, L + 17);
        wait_cyc(L + 22);
        chk("coll_no_restart", n_ld, 1);
        clr_spif("coll_spif_clr");

        // synchronous reset mid-transfer
        xfer_start();
        wait_cyc(L + 3);
        preset = 1'b1;
        wait_cyc(L + 4);
        chk("mrst_ss", ifc.ss, 1);
        chk("mrst_tip", ifc.tip, 0);
        chk("mrst_sclk", ifc.sclk, 0);
        preset = 1'b0;
        wait_cyc(L + 25);
        chk("mrst_rd_cnt", n_rd, 0);
        chk("mrst_samp_cnt", n_r, 1);
        chk("mrst_spif", ifc.spif, 0);

`ifdef SPI_MODF_EN
        // mode fault aborts, sets modf; fault in IDLE blocks start
        xfer_start();
        wait_cyc(L + 3);
        ifc.ss_fault_n = 1'b0;
        wait_cyc(L + 4);
        chk("modf_ss", ifc.ss, 1);
        chk("modf_set", ifc.modf, 1);
        ifc.ss_fault_n = 1'b1;
        ifc.spif_clr = 1'b1;
        wait_cyc(L + 5);
        ifc.spif_clr = 1'b0;
        chk("modf_clr", ifc.modf, 0);
        wait_cyc(L + 25);
        chk("modf_rd_cnt", n_rd, 0);
        chk("modf_spif", ifc.spif, 0);
        ifc.ss_fault_n = 1'b0;
        mon_clr();
        ifc.start = 1'b1;
        wait_cyc(cyc + 1);
        ifc.start = 1'b0;
        wait_cyc(cyc + 4);
        chk("modf_idle_block", n_ld, 0);
        ifc.ss_fault_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Master-side transfer sequencer for the SPI shift register. It turns one transfer request into the SCLK waveform for the selected CPOL/CPHA mode. It also generates the slave-select, load and capture pulses, and the per-edge shift/sample strobes that the shift register consumes. It sits between the APB register block (which supplies configuration and the start request) and the shift register (which moves the bits).

## Interface
Parameters:
- none. Baud divisor range is fixed by the 3-bit `sppr`/`spr` fields.

Ports:
- `pclk` in 1: system clock; all logic on its rising edge.
- `preset` in 1: reset, synchronous, active-high.
- `spe` in 1: SPI enable; low aborts and blocks transfers.
- `cpol` in 1, `cpha` in 1: SPI mode.
- `sppr` in 3, `spr` in 3: baud selects.
- `start` in 1: request pulse, written by the data-register write path.
- `spif_clr` in 1: clears `spif`.
- `send_data` out 1: one-cycle pulse that loads the shift register.
- `recieve_data` out 1: one-cycle pulse; the shift register presents received data during this pulse.
- `ss` out 1: slave select, active-low.
- `sclk` out 1: serial clock.
- `mosi_send_sclk`, `miso_recieve_sclk` out 1: shift/sample strobes, used only when `cpol==cpha`.
- `mosi_send_sclk0`, `miso_recieve_sclk0` out 1: shift/sample strobes, used only when `cpol!=cpha`.
- `tip` out 1: transfer in progress.
- `spif` out 1: sticky transfer-complete flag.

## Operation
- Half-period `H = (sppr+1) * 2^spr` pclk cycles, ranging 1..1024. Baud divisor is `2H`.
- `cpol`, `cpha`, `sppr` and `spr` are latched in LOAD and held for the whole transfer.
- FSM states: IDLE, LOAD, ACTIVE, TAIL.
  - IDLE:
    - `ss`=1, `tip`=0, `sclk` is registered from live `cpol`.
    - `start && spe` moves to LOAD.
    - `start` while `!spe` is ignored.
  - LOAD (1 cycle):
    - `send_data`=1, `ss`=0, `tip`=1.
    - Half-period counter and edge counter are cleared.
    - Moves to ACTIVE.
  - ACTIVE:
    - Counter runs 0..H-1. At H-1 a tick occurs: `sclk` toggles, edge index e (0..15) increments, and the counter wraps.
    - After tick with e=15, moves to TAIL.
  - TAIL:
    - Holds `ss`=0 for H cycles.
    - On the last TAIL cycle: `recieve_data`=1 and `spif` is set.
    - Moves to IDLE.
- Strobes are one-cycle pulses, coincident with the tick cycle unless noted. Each pulse drives the mode-selected pair only; the other pair stays 0.
  - `cpha=0`:
    - Sample strobe on even e (0, 2, …, 14).
    - Send strobe on the first ACTIVE cycle and on odd e = 1, 3, …, 13.
  - `cpha=1`:
    - Send strobe on even e.
    - Sample strobe on odd e.
  - Every transfer yields exactly 8 send and 8 sample strobes.
- `spe` falling in LOAD/ACTIVE/TAIL aborts the transfer:
  - Next cycle is IDLE, with `ss`=1 and `sclk`=`cpol`.
  - No `recieve_data` pulse; `spif` is unchanged.
- `start` in any state other than IDLE is ignored; requests are not queued.
- `spif_clr` and `spif` set in the same cycle: set wins.

## Timing
- Reset values: state IDLE; `ss`=1; `sclk`=0; `tip`=0; `spif`=0; `send_data`, `recieve_data` and all strobes 0. `modf`=0 when present.
- `start` sampled at cycle t:
  - LOAD (`send_data`) at t+1 = L.
  - First `sclk` edge at L+H.
  - Last edge at L+16H.
  - `recieve_data` at L+17H.
  - `ss`=1 and `tip`=0 from L+17H+1.
- Total busy window is 17H+1 cycles.
- Back-to-back transfers: earliest next LOAD is L+17H+2, so `ss` is high for at least 1 cycle between transfers.
- Reset mid-transfer: IDLE values on the next cycle; no pulses are emitted.

## Configuration
- Macro: `SPI_MODF_EN`.
- Defined:
  - Adds input `ss_fault_n` (1) and output `modf` (1, sticky).
  - `ss_fault_n`==0 in LOAD/ACTIVE/TAIL aborts exactly like the `spe` abort and sets `modf`.
  - `ss_fault_n`==0 in IDLE blocks `start`.
  - `modf` is cleared by `spif_clr`.
- Undefined: neither port exists; fault detection is absent.

## Test plan
- Mode 0, sppr=0, spr=0 (H=1), `start` at t:
  - `send_data` at t+1.
  - 16 `sclk` toggles at t+2..t+17.
  - Sample strobes (`miso_recieve_sclk`) at t+2, 4, …, 16.
  - `recieve_data` at t+18; `spif`=1 and `ss`=1 at t+19.
- Mode 1 (cpol=0, cpha=1), sppr=2, spr=1 (H=6):
  - `sclk` period is 12 cycles.
  - `recieve_data` at L+102.
  - Only the `*_sclk0` strobes pulse, 8 of each.
  - First `mosi_send_sclk0` at L+6.
- Mode 3, H=1:
  - `sclk` idles 1, ends 1.
  - `mosi_send_sclk` on even edges, `miso_recieve_sclk` on odd edges.
- `spe` dropped at L+5 (H=1):
  - IDLE at L+6 with `ss`=1.
  - No `recieve_data`; `spif` stays 0.
  - `start` with `spe`=0 produces no `send_data`.
- `start` pulsed mid-transfer: ignored. `spif_clr` on the same cycle `spif` sets: `spif`=1.
- `SPI_MODF_EN`: `ss_fault_n`=0 at L+3:
  - Abort at L+4; `modf`=1.
  - `spif_clr` clears `modf`.
